// File: rtl/ss_sort_ctrl_if.sv
// ss_sort_ctrl_if
//   Bundles everything ss_sort_ctrl exchanges with its neighbours except clock
//   and reset.
//   - Control side (top-level sort FSM): i_start, i_si, i_ei in; o_busy, o_done out.
//   - Read-data unit side: o_start_read_data, o_en_read_data, o_si_ram, o_ei_ram
//     out; i_data_ram, i_data_valid, i_done_read_data in.
//   - RAM write port: o_wr_en, o_wr_addr, o_wr_data out.
//   Modports:
//   - master: the sequencer's view.
//   - slave: the environment's view (sort FSM, read unit and RAM).
interface ss_sort_ctrl_if #(
  parameter int SIZE_ADDR = 6,
  parameter int SIZE_DATA = 8
);
  logic                 i_start;
  logic [SIZE_ADDR-1:0] i_si;
  logic [SIZE_ADDR-1:0] i_ei;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_start_read_data;
  logic                 o_en_read_data;
  logic [SIZE_ADDR-1:0] o_si_ram;
  logic [SIZE_ADDR-1:0] o_ei_ram;
  logic [SIZE_DATA-1:0] i_data_ram;
  logic                 i_data_valid;
  logic                 i_done_read_data;
  logic                 o_wr_en;
  logic [SIZE_ADDR-1:0] o_wr_addr;
  logic [SIZE_DATA-1:0] o_wr_data;

  modport master (
    input  i_start, i_si, i_ei, i_data_ram, i_data_valid, i_done_read_data,
    output o_busy, o_done, o_start_read_data, o_en_read_data, o_si_ram,
           o_ei_ram, o_wr_en, o_wr_addr, o_wr_data
  );

  modport slave (
    output i_start, i_si, i_ei, i_data_ram, i_data_valid, i_done_read_data,
    input  o_busy, o_done, o_start_read_data, o_en_read_data, o_si_ram,
           o_ei_ram, o_wr_en, o_wr_addr, o_wr_data
  );
endinterface

// File: rtl/ss_sort_ctrl.sv
// ss_sort_ctrl
//   Selection-sort sequencer for the RAM window [i_si, i_ei].
//   - Each position cur_i gets one scan pass through the read-data unit, which
//     streams words cur_i..ei back.
//   - The running minimum of that stream is tracked. Ties keep the first
//     occurrence.
//   - When the minimum is not already at cur_i, two RAM writes swap it into place.
//   Ports:
//   - i_clk, i_rst: clock, synchronous active-high reset.
//   - bus (ss_sort_ctrl_if.master): start/range/busy/done towards the sort FSM,
//     the pass request and data stream of the read unit, and the RAM write port.
//   Outputs are decoded from the state and registers only, so a reset takes
//   every output to 0 on the following cycle.
module ss_sort_ctrl #(
  parameter int SIZE_ADDR = 6,
  parameter int SIZE_DATA = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  ss_sort_ctrl_if.master  bus
);
  localparam int CW = SIZE_ADDR + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_SCAN   = 3'd2;
  localparam logic [2:0] S_WR_LO  = 3'd3;
  localparam logic [2:0] S_WR_HI  = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]           state_q,     state_d;
  logic [SIZE_ADDR-1:0] ei_q,        ei_d;
  logic [SIZE_ADDR-1:0] cur_i_q,     cur_i_d;
  logic [CW-1:0]        scan_addr_q, scan_addr_d;
  logic [SIZE_DATA-1:0] first_val_q, first_val_d;
  logic [SIZE_DATA-1:0] min_val_q,   min_val_d;
  logic [CW-1:0]        min_addr_q,  min_addr_d;
  logic [CW-1:0]        rx_cnt_q,    rx_cnt_d;
  logic                 done_seen_q, done_seen_d;

  // Words expected in the current pass. This is evaluated one bit wider, so a
  // window covering the whole address space still counts correctly.
  logic [CW-1:0] exp_cnt;
  assign exp_cnt = {1'b0, ei_q} - {1'b0, cur_i_q} + CW'(1);

  always_comb begin
    state_d     = state_q;
    ei_d        = ei_q;
    cur_i_d     = cur_i_q;
    scan_addr_d = scan_addr_q;
    first_val_d = first_val_q;
    min_val_d   = min_val_q;
    min_addr_d  = min_addr_q;
    rx_cnt_d    = rx_cnt_q;
    done_seen_d = done_seen_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          if (bus.i_si < bus.i_ei) begin
            ei_d    = bus.i_ei;
            cur_i_d = bus.i_si;
            state_d = S_LAUNCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_LAUNCH: begin
        rx_cnt_d    = '0;
        done_seen_d = 1'b0;
        scan_addr_d = {1'b0, cur_i_q};
        state_d     = S_SCAN;
      end
      S_SCAN: begin
        if (bus.i_done_read_data) begin
          done_seen_d = 1'b1;
        end
        // Valids beyond the expected count are dropped.
        if (bus.i_data_valid && (rx_cnt_q < exp_cnt)) begin
          if (rx_cnt_q == '0) begin
            first_val_d = bus.i_data_ram;
            min_val_d   = bus.i_data_ram;
            min_addr_d  = scan_addr_q;
          end else if (bus.i_data_ram < min_val_q) begin
            min_val_d  = bus.i_data_ram;
            min_addr_d = scan_addr_q;
          end
          scan_addr_d = scan_addr_q + CW'(1);
          rx_cnt_d    = rx_cnt_q + CW'(1);
        end
        // The decision is made on registered values, so the last word and the
        // done flag may arrive in either order.
        if ((rx_cnt_q == exp_cnt) && done_seen_q) begin
          state_d = (min_addr_q == {1'b0, cur_i_q}) ? S_NEXT : S_WR_LO;
        end
      end
      S_WR_LO: state_d = S_WR_HI;
      S_WR_HI: state_d = S_NEXT;
      S_NEXT: begin
        cur_i_d = cur_i_q + SIZE_ADDR'(1);
        // The last position needs no pass of its own.
        if (({1'b0, cur_i_q} + CW'(1)) == {1'b0, ei_q}) begin
          state_d = S_DONE;
        end else begin
          state_d = S_LAUNCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      ei_q        <= '0;
      cur_i_q     <= '0;
      scan_addr_q <= '0;
      first_val_q <= '0;
      min_val_q   <= '0;
      min_addr_q  <= '0;
      rx_cnt_q    <= '0;
      done_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ei_q        <= ei_d;
      cur_i_q     <= cur_i_d;
      scan_addr_q <= scan_addr_d;
      first_val_q <= first_val_d;
      min_val_q   <= min_val_d;
      min_addr_q  <= min_addr_d;
      rx_cnt_q    <= rx_cnt_d;
      done_seen_q <= done_seen_d;
    end
  end

  logic busy;
  logic in_pass;
  assign busy    = (state_q != S_IDLE);
  assign in_pass = (state_q == S_LAUNCH) || (state_q == S_SCAN);

  assign bus.o_busy            = busy;
  assign bus.o_done            = (state_q == S_DONE);
  assign bus.o_start_read_data = in_pass;
  assign bus.o_en_read_data    = in_pass;
  assign bus.o_si_ram          = busy ? cur_i_q : '0;
  assign bus.o_ei_ram          = busy ? ei_q : '0;
  assign bus.o_wr_en           = (state_q == S_WR_LO) || (state_q == S_WR_HI);
  assign bus.o_wr_addr         = (state_q == S_WR_LO) ? cur_i_q :
                                 (state_q == S_WR_HI) ? min_addr_q[SIZE_ADDR-1:0] : '0;
  assign bus.o_wr_data         = (state_q == S_WR_LO) ? min_val_q :
                                 (state_q == S_WR_HI) ? first_val_q : '0;
endmodule

// File: tb/tb_ss_sort_ctrl.sv
// Testbench for ss_sort_ctrl.
//   The bench models the RAM and the read-data unit.
//   A reference selection sort fills a queue of expected writes before each run,
//   and the DUT's writes are popped from it and compared.
//   A vector table covers the main cases. Hand-written sequences cover reset
//   mid-sort and the full 64-word window.
module tb_ss_sort_ctrl;
  localparam int A = 6;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ss_sort_ctrl_if #(.SIZE_ADDR(A), .SIZE_DATA(D)) bus ();
  ss_sort_ctrl #(.SIZE_ADDR(A), .SIZE_DATA(D)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] ram   [64];
  logic [7:0] model [64];

  typedef struct packed {
    logic [A-1:0] addr;
    logic [D-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct packed {
    logic [63:0] init;
    int          si;
    int          ei;
    int          gaps;
    int          dup_cyc;
    int          exp_w;
    int          exp_p;
    logic [63:0] fin;
  } vec_t;

  int   n_writes, n_passes, n_done, done_cyc;
  logic bus_bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] p8(input int a0, input int a1, input int a2, input int a3,
                                     input int a4, input int a5, input int a6, input int a7);
    return {8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic logic [63:0] all_outs();
    return {bus.o_busy, bus.o_done, bus.o_start_read_data, bus.o_en_read_data,
            bus.o_si_ram, bus.o_ei_ram, bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data};
  endfunction

  // Runs one sort. The read unit streams ram[si..ei] after each rising edge
  // of o_start_read_data.
  // - gap_max > 0: each word after the first is delayed by 1..gap_max cycles.
  // - dup_cyc > 0: a second i_start is pulsed on that cycle.
  // - rst_pass >= 0: reset is asserted after the first word of that pass.
  task automatic run_sort(input int si, input int ei, input int gap_max, input int dup_cyc,
                          input int rst_pass, input string tag);
    int   m, cyc, rd_addr, rd_end, gap, rd_cnt;
    logic rd_active, done_pend, prev_start, rst_armed;
    wr_t  w;
    logic [7:0] t;
    for (int k = 0; k < 64; k++) model[k] = ram[k];
    exp_q.delete();
    for (int i = si; i < ei; i++) begin
      m = i;
      for (int j = i + 1; j <= ei; j++) if (model[j] < model[m]) m = j;
      if (m != i) begin
        w.addr = 6'(i); w.data = model[m]; exp_q.push_back(w);
        w.addr = 6'(m); w.data = model[i]; exp_q.push_back(w);
        t = model[i]; model[i] = model[m]; model[m] = t;
      end
    end
    n_writes = 0; n_passes = 0; n_done = 0; done_cyc = -1; bus_bad = 1'b0;
    rd_active = 1'b0; done_pend = 1'b0; prev_start = 1'b0; rst_armed = 1'b0;
    rd_addr = 0; rd_end = 0; gap = 0; rd_cnt = 0; cyc = 0;

    @(negedge clk);
    bus.i_start = 1'b1; bus.i_si = 6'(si); bus.i_ei = 6'(ei);
    while (1) begin
      @(negedge clk);
      cyc++;
      if (rst_armed) begin
        check({tag, " outs_after_rst"}, all_outs(), 64'd0);
        check({tag, " busy_after_rst"}, {63'd0, bus.o_busy}, 64'd0);
        rst = 1'b0;
        break;
      end
      bus.i_start = (cyc == dup_cyc);
      if (cyc == dup_cyc) begin
        bus.i_si = 6'd0; bus.i_ei = 6'd7;
      end
      if (cyc == 1) check({tag, " busy_rise"}, {63'd0, bus.o_busy}, 64'd1);
      if (bus.o_wr_en) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          check({tag, " unexpected_write"}, {58'd0, bus.o_wr_addr}, 64'hFFFF);
        end else begin
          w = exp_q.pop_front();
          check({tag, " wr_addr"}, {58'd0, bus.o_wr_addr}, {58'd0, w.addr});
          check({tag, " wr_data"}, {56'd0, bus.o_wr_data}, {56'd0, w.data});
        end
        ram[bus.o_wr_addr] = bus.o_wr_data;
      end else if (bus.o_wr_addr != 0 || bus.o_wr_data != 0) begin
        bus_bad = 1'b1;
      end
      if (!bus.o_busy && (all_outs() != 0)) bus_bad = 1'b1;
      if (bus.o_done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      bus.i_data_valid = 1'b0; bus.i_done_read_data = 1'b0;
      if (bus.o_start_read_data && !prev_start && bus.o_en_read_data) begin
        n_passes++;
        rd_active = 1'b1; done_pend = 1'b0; gap = 0; rd_cnt = 0;
        rd_addr = int'(bus.o_si_ram); rd_end = int'(bus.o_ei_ram);
      end else if (rd_active) begin
        if (done_pend) begin
          bus.i_done_read_data = 1'b1; rd_active = 1'b0;
        end else if (gap > 0) begin
          gap--;
        end else begin
          bus.i_data_valid = 1'b1; bus.i_data_ram = ram[rd_addr];
          if (rd_addr == rd_end) done_pend = 1'b1;
          rd_addr++; rd_cnt++;
          gap = (gap_max > 0) ? int'($urandom_range(gap_max, 1)) : 0;
        end
      end
      prev_start = bus.o_start_read_data;
      if (rst_pass >= 0 && n_passes == rst_pass + 1 && rd_cnt == 1 && rd_active) begin
        rst = 1'b1; rst_armed = 1'b1;
      end
      if (done_cyc >= 0 && cyc > done_cyc) break;
      if (cyc > 20000) begin
        check({tag, " timeout"}, 64'd1, 64'd0);
        break;
      end
    end
    bus.i_start = 1'b0; bus.i_data_valid = 1'b0; bus.i_done_read_data = 1'b0;
    if (rst_pass < 0) begin
      check({tag, " busy_fall"}, {63'd0, bus.o_busy}, 64'd0);
      check({tag, " done_count"}, 64'(n_done), 64'd1);
      check({tag, " idle_bus"}, {63'd0, bus_bad}, 64'd0);
      check({tag, " writes_left"}, 64'(exp_q.size()), 64'd0);
    end
    $display("run %s: si=%0d ei=%0d writes=%0d passes=%0d done_cyc=%0d",
             tag, si, ei, n_writes, n_passes, done_cyc);
  endtask

  vec_t vecs [8];
  logic [63:0] got;
  int sorted_ok;

  initial begin
    rst = 1'b1;
    bus.i_start = 1'b0; bus.i_si = '0; bus.i_ei = '0;
    bus.i_data_ram = '0; bus.i_data_valid = 1'b0; bus.i_done_read_data = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", all_outs(), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outs", all_outs(), 64'd0);

    vecs[0] = '{p8(3,1,2,0,0,0,0,0), 0, 3, 0, -1, 2, 3, p8(0,1,2,3,0,0,0,0)};
    vecs[1] = '{p8(1,2,3,4,0,0,0,0), 0, 3, 0, -1, 0, 3, p8(1,2,3,4,0,0,0,0)};
    vecs[2] = '{p8(2,1,1,0,0,0,0,0), 0, 2, 0, -1, 4, 2, p8(1,1,2,0,0,0,0,0)};
    vecs[3] = '{p8(9,9,9,9,9,7,9,9), 5, 5, 0, -1, 0, 0, p8(9,9,9,9,9,7,9,9)};
    vecs[4] = '{p8(5,4,3,2,1,0,7,6), 6, 2, 0, -1, 0, 0, p8(5,4,3,2,1,0,7,6)};
    vecs[5] = '{p8(3,1,2,0,0,0,0,0), 0, 3, 3,  4, 2, 3, p8(0,1,2,3,0,0,0,0)};
    vecs[6] = '{p8(7,6,5,4,3,2,1,0), 0, 7, 2, -1, 8, 7, p8(0,1,2,3,4,5,6,7)};
    vecs[7] = '{p8(9,8,7,6,5,4,3,2), 2, 5, 1, -1, 4, 3, p8(9,8,4,5,6,7,3,2)};

    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < 64; k++) ram[k] = 8'hAA;
      for (int k = 0; k < 8; k++) ram[k] = vecs[v].init[8*k +: 8];
      run_sort(vecs[v].si, vecs[v].ei, vecs[v].gaps, vecs[v].dup_cyc, -1, $sformatf("vec%0d", v));
      check($sformatf("vec%0d writes", v), 64'(n_writes), 64'(vecs[v].exp_w));
      check($sformatf("vec%0d passes", v), 64'(n_passes), 64'(vecs[v].exp_p));
      for (int k = 0; k < 8; k++) got[8*k +: 8] = ram[k];
      check($sformatf("vec%0d final", v), got, vecs[v].fin);
      if (vecs[v].exp_p == 0) check($sformatf("vec%0d done_lat", v), 64'(done_cyc), 64'd1);
    end

    // Reset during the second pass, then a fresh sort from scratch.
    for (int k = 0; k < 64; k++) ram[k] = 8'hAA;
    for (int k = 0; k < 8; k++) ram[k] = 8'(p8(3,1,2,0,0,0,0,0) >> (8*k));
    run_sort(0, 3, 0, -1, 1, "rst_mid");
    @(negedge clk);
    check("rst_mid idle", all_outs(), 64'd0);
    for (int k = 0; k < 8; k++) ram[k] = 8'(p8(4,3,2,1,0,0,0,0) >> (8*k));
    run_sort(0, 3, 0, -1, -1, "after_rst");
    for (int k = 0; k < 8; k++) got[8*k +: 8] = ram[k];
    check("after_rst final", got, p8(1,2,3,4,0,0,0,0));
    check("after_rst writes", 64'(n_writes), 64'd4);

    // Full address window 0..63.
    for (int k = 0; k < 64; k++) ram[k] = 8'($urandom_range(255, 0));
    ram[0] = 8'd255; ram[63] = 8'd0;
    run_sort(0, 63, 0, -1, -1, "full");
    check("full passes", 64'(n_passes), 64'd63);
    sorted_ok = 1;
    for (int k = 0; k < 63; k++) if (ram[k] > ram[k+1]) sorted_ok = 0;
    check("full sorted", 64'(sorted_ok), 64'd1);
    check("full ends", {48'd0, ram[0], ram[63]}, {48'd0, 8'd0, 8'd255});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
